fetch_decode_unit: RTL and testbench

- Parametrised successor to the combinational fetch/decode stage.
- Owns the PC register and the IF/ID pipeline register, and drives the address of an external instruction memory.
- Resolves J in-stage with no bubble, accepts a branch redirect and flush from EX, supports stall, and latches a sticky HALT state on the END word.
- Sits between the instruction memory and the register-file/EX stage of the 5-bit-opcode processor.

---
 rtl/fetch_decode_unit.sv | 121 ++++++++++++
 tb/tb_fetch_decode_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_unit.sv
// Fetch/decode stage: owns the PC and the IF/ID register, resolves J in-stage,
// takes branch redirects from EX, and parks in a sticky HALT on the END word.
module fetch_decode_unit #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [31:0]     NOP_WORD = 32'hF800_0000,
  parameter logic [31:0]     END_WORD = 32'hFFFF_FFFF,
  parameter logic [4:0]      J_OPCODE = 5'd16,
  parameter int              CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [PC_W-1:0]  br_target,
  output logic [PC_W-1:0]  imem_addr,
  input  logic [31:0]      imem_data,
  output logic [31:0]      instr,
  output logic [4:0]       opcode,
  output logic [4:0]       rd,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [16:0]      imm,
  output logic [PC_W-1:0]  jaddr,
  output logic [PC_W-1:0]  pc_out,
  output logic [PC_W-1:0]  next_pc,
  output logic             valid,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_cnt
);

  typedef enum logic {RUN, HALT} state_t;

  typedef struct packed {
    logic [31:0]     instr;
    logic [PC_W-1:0] pc;
    logic            valid;
  } ifid_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  ifid_t             ifid_q, ifid_d;
  logic              halted_q, halted_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // 27-bit jump field zero-extended, or truncated when PC_W is narrower
  logic [63:0]       jfetch_ext, jout_ext;
  logic [PC_W-1:0]   jfetch;

  assign jfetch_ext = {37'd0, imem_data[26:0]};
  assign jout_ext   = {37'd0, ifid_q.instr[26:0]};
  assign jfetch     = jfetch_ext[PC_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      ifid_q   <= '{instr: NOP_WORD, pc: RESET_PC, valid: 1'b0};
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ifid_q   <= ifid_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ifid_d   = ifid_q;
    halted_d = halted_q;
    cnt_d    = cnt_q;
    case (state_q)
      RUN: begin
        if (br_taken) begin
          // redirect wins over stall and END; the word in flight is dropped
          pc_d         = br_target;
          ifid_d.instr = NOP_WORD;
          ifid_d.valid = 1'b0;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (imem_data == END_WORD) begin
          state_d      = HALT;
          halted_d     = 1'b1;
          ifid_d.instr = NOP_WORD;
          ifid_d.valid = 1'b0;
        end else begin
          ifid_d.instr = imem_data;
          ifid_d.pc    = pc_q;
          ifid_d.valid = 1'b1;
          cnt_d        = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
          pc_d         = (imem_data[31:27] == J_OPCODE) ? jfetch : pc_q + PC_W'(1);
        end
      end
      HALT: begin
        ifid_d.instr = NOP_WORD;
        ifid_d.valid = 1'b0;
        halted_d     = 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  assign imem_addr = pc_q;
  assign next_pc   = rst ? RESET_PC : pc_d;
  assign instr     = ifid_q.instr;
  assign opcode    = ifid_q.instr[31:27];
  assign rd        = ifid_q.instr[26:22];
  assign rs        = ifid_q.instr[21:17];
  assign rt        = ifid_q.instr[16:12];
  assign imm       = ifid_q.instr[16:0];
  assign jaddr     = jout_ext[PC_W-1:0];
  assign pc_out    = ifid_q.pc;
  assign valid     = ifid_q.valid;
  assign halted    = halted_q;
  assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Bench for fetch_decode_unit: default-width instance checked every cycle
// against a behavioural model, plus a narrow instance for wrap/saturation.
module tb_fetch_decode_unit;

  localparam logic [31:0] NOP = 32'hF800_0000;
  localparam logic [31:0] ENDW = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance
  logic        rst = 1'b1, stall = 1'b0, br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic [31:0] imem_addr, imem_data, instr, jaddr, pc_out, next_pc;
  logic [4:0]  opcode, rd, rs, rt;
  logic [16:0] imm;
  logic        valid, halted;
  logic [15:0] fetch_cnt;
  logic [31:0] mem [64];

  assign imem_data = mem[imem_addr[5:0]];

  fetch_decode_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken), .br_target(br_target),
    .imem_addr(imem_addr), .imem_data(imem_data), .instr(instr), .opcode(opcode),
    .rd(rd), .rs(rs), .rt(rt), .imm(imm), .jaddr(jaddr), .pc_out(pc_out),
    .next_pc(next_pc), .valid(valid), .halted(halted), .fetch_cnt(fetch_cnt)
  );

  // narrow instance: PC_W=4, CNT_W=2
  logic        s_rst = 1'b1;
  logic        s_stall = 1'b0, s_br = 1'b0;
  logic [3:0]  s_tgt = '0;
  logic [3:0]  s_addr, s_jaddr, s_pc_out, s_next_pc;
  logic [31:0] s_data, s_instr;
  logic [4:0]  s_opcode, s_rd, s_rs, s_rt;
  logic [16:0] s_imm;
  logic        s_valid, s_halted;
  logic [1:0]  s_cnt;
  logic [31:0] mem2 [16];

  assign s_data = mem2[s_addr];

  fetch_decode_unit #(.PC_W(4), .RESET_PC(4'd0), .CNT_W(2)) dut_s (
    .clk(clk), .rst(s_rst), .stall(s_stall), .br_taken(s_br), .br_target(s_tgt),
    .imem_addr(s_addr), .imem_data(s_data), .instr(s_instr), .opcode(s_opcode),
    .rd(s_rd), .rs(s_rs), .rt(s_rt), .imm(s_imm), .jaddr(s_jaddr), .pc_out(s_pc_out),
    .next_pc(s_next_pc), .valid(s_valid), .halted(s_halted), .fetch_cnt(s_cnt)
  );

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // behavioural model of the default-width instance
  logic [31:0] m_pc, m_instr, m_pcout;
  logic        m_valid, m_halted;
  logic [15:0] m_cnt;

  task automatic step(input logic r, input logic s, input logic b, input logic [31:0] t);
    logic [31:0] word, n_pc, n_instr, n_pcout;
    logic        n_valid, n_halted;
    logic [15:0] n_cnt;
    rst = r; stall = s; br_taken = b; br_target = t;
    #1;
    word = mem[m_pc[5:0]];
    n_pc = m_pc; n_instr = m_instr; n_pcout = m_pcout;
    n_valid = m_valid; n_halted = m_halted; n_cnt = m_cnt;
    if (r) begin
      n_pc = 0; n_instr = NOP; n_pcout = 0; n_valid = 0; n_halted = 0; n_cnt = 0;
    end else if (m_halted) begin
      n_instr = NOP; n_valid = 0;
    end else if (b) begin
      n_pc = t; n_instr = NOP; n_valid = 0;
    end else if (s) begin
      n_pc = m_pc;
    end else if (word == ENDW) begin
      n_halted = 1; n_instr = NOP; n_valid = 0;
    end else begin
      n_instr = word; n_pcout = m_pc; n_valid = 1;
      if (m_cnt != 16'hFFFF) n_cnt = m_cnt + 16'd1;
      n_pc = (word[31:27] == 5'd16) ? {5'd0, word[26:0]} : m_pc + 32'd1;
    end
    chk("imem_addr", imem_addr, m_pc);
    chk("next_pc", next_pc, n_pc);
    @(posedge clk); #1;
    m_pc = n_pc; m_instr = n_instr; m_pcout = n_pcout;
    m_valid = n_valid; m_halted = n_halted; m_cnt = n_cnt;
    chk("instr", instr, m_instr);
    chk("opcode", {27'd0, opcode}, {27'd0, m_instr[31:27]});
    chk("rd", {27'd0, rd}, {27'd0, m_instr[26:22]});
    chk("rs", {27'd0, rs}, {27'd0, m_instr[21:17]});
    chk("rt", {27'd0, rt}, {27'd0, m_instr[16:12]});
    chk("imm", {15'd0, imm}, {15'd0, m_instr[16:0]});
    chk("jaddr", jaddr, {5'd0, m_instr[26:0]});
    chk("pc_out", pc_out, m_pcout);
    chk("valid", {31'd0, valid}, {31'd0, m_valid});
    chk("halted", {31'd0, halted}, {31'd0, m_halted});
    chk("fetch_cnt", {16'd0, fetch_cnt}, {16'd0, m_cnt});
  endtask

  task automatic go(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  task automatic s_cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0800_0000 | i;
    for (int i = 0; i < 16; i++) mem2[i] = 32'h0800_0000 | i;
    mem[0]  = 32'h1042_0001;
    mem[1]  = 32'h1084_0003;
    mem[14] = 32'h8000_0012;
    mem[19] = ENDW;
    mem[40] = 32'h8000_0028;
    m_pc = 0; m_instr = NOP; m_pcout = 0; m_valid = 0; m_halted = 0; m_cnt = 0;

    step(1, 0, 0, 0); step(1, 0, 0, 0);
    chk("rst_opcode", {27'd0, opcode}, 32'd31);
    chk("rst_instr", instr, NOP);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_cnt", {16'd0, fetch_cnt}, 32'd0);

    go(1);
    chk("addi0_opcode", {27'd0, opcode}, 32'd2);
    chk("addi0_rd", {27'd0, rd}, 32'd1);
    chk("addi0_rs", {27'd0, rs}, 32'd1);
    chk("addi0_imm", {15'd0, imm}, 32'd1);
    chk("addi0_pc_out", pc_out, 32'd0);
    chk("addi0_valid", {31'd0, valid}, 32'd1);
    go(1);
    chk("addi1_rd", {27'd0, rd}, 32'd2);
    chk("addi1_imm", {15'd0, imm}, 32'd3);
    chk("addi1_cnt", {16'd0, fetch_cnt}, 32'd2);

    go(12);
    go(1);  // J 18 at PC 14
    chk("j_addr", imem_addr, 32'd18);
    chk("j_valid", {31'd0, valid}, 32'd1);
    chk("j_opcode", {27'd0, opcode}, 32'd16);
    chk("j_pc_out", pc_out, 32'd14);

    step(0, 1, 1, 15);  // branch beats stall
    chk("br_addr", imem_addr, 32'd15);
    chk("br_instr", instr, NOP);
    chk("br_valid", {31'd0, valid}, 32'd0);
    go(1);
    chk("br_fetch_pc", pc_out, 32'd15);

    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    chk("stall_instr", instr, 32'h0800_000F);
    chk("stall_addr", imem_addr, 32'd16);
    chk("stall_cnt", {16'd0, fetch_cnt}, 32'd16);
    go(1);
    chk("resume_pc_out", pc_out, 32'd16);
    chk("resume_cnt", {16'd0, fetch_cnt}, 32'd17);

    go(2);
    step(0, 0, 1, 17);  // END in flight, branch wins
    chk("endbr_halted", {31'd0, halted}, 32'd0);
    chk("endbr_addr", imem_addr, 32'd17);
    go(3);
    chk("halt_halted", {31'd0, halted}, 32'd1);
    chk("halt_instr", instr, NOP);
    chk("halt_addr", imem_addr, 32'd19);
    step(0, 0, 1, 5); step(0, 1, 0, 0); go(2);
    chk("halt_sticky", {31'd0, halted}, 32'd1);
    chk("halt_frozen_addr", imem_addr, 32'd19);

    step(1, 0, 0, 0);
    chk("halt_rst_addr", imem_addr, 32'd0);
    chk("halt_rst_halted", {31'd0, halted}, 32'd0);

    step(0, 0, 1, 40); go(3);  // self-loop J at 40
    chk("loop_addr", imem_addr, 32'd40);
    chk("loop_pc_out", pc_out, 32'd40);
    step(0, 1, 0, 0); step(1, 1, 0, 0);
    chk("stallrst_addr", imem_addr, 32'd0);
    chk("stallrst_valid", {31'd0, valid}, 32'd0);

    // narrow instance: wrap and saturation
    s_rst = 1'b1; s_cyc(1);
    chk("s_rst_cnt", {30'd0, s_cnt}, 32'd0);
    s_rst = 1'b0; s_cyc(2);
    chk("s_cnt2", {30'd0, s_cnt}, 32'd2);
    s_cyc(3);
    chk("s_cnt_sat", {30'd0, s_cnt}, 32'd3);
    s_cyc(10);
    chk("s_addr15", {28'd0, s_addr}, 32'd15);
    chk("s_next_wrap", {28'd0, s_next_pc}, 32'd0);
    s_cyc(1);
    chk("s_wrap_addr", {28'd0, s_addr}, 32'd0);
    chk("s_wrap_pc_out", {28'd0, s_pc_out}, 32'd15);
    chk("s_wrap_cnt", {30'd0, s_cnt}, 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
